// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and the writeback entry type.
package cpu_pkg;

    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 4;

    // One pending register write: destination and value.
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Writeback request handshake between the pipeline and regfile_writeback.
interface regfile_writeback_if #(
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
    parameter int unsigned DATA_W = cpu_pkg::DATA_W
);

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ready;

    // Pipeline side: issues requests, observes acceptance.
    modport master (
        output wb_valid,
        output wb_rd,
        output wb_data,
        input  wb_ready
    );

    // Writeback buffer side: consumes requests, grants acceptance.
    modport slave (
        input  wb_valid,
        input  wb_rd,
        input  wb_data,
        output wb_ready
    );

endinterface

// File: rtl/wb_fifo.sv
// Pending-write storage: circular buffer with explicit occupancy count.
// All entries are exposed oldest-first with valid bits so the caller can
// run forwarding compares without knowing the pointer positions.
module wb_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_rd_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [CNT_W-1:0]  count_o,
    output logic [ADDR_W-1:0] ent_rd_o   [DEPTH],
    output logic [DATA_W-1:0] ent_data_o [DEPTH],
    output logic [DEPTH-1:0]  ent_valid_o
);

    import cpu_pkg::*;

    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  idx;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; a push writes the slot at the write pointer.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else if (push_i) begin
            rd_q[wr_ptr_q]   <= push_rd_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Rotate storage into age order: slot 0 is the head (oldest).
    always_comb begin
        idx = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx            = rd_ptr_q + PTR_W'(k);
            ent_rd_o[k]    = rd_q[idx];
            ent_data_o[k]  = data_q[idx];
            ent_valid_o[k] = (CNT_W'(k) < count_q);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Writeback buffer in front of registerFile: accepts writeback requests,
// drains one entry per cycle into the register file write port, and
// forwards not-yet-committed data onto the RS/RT read paths.
module regfile_writeback #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                Clock,
    input  logic                Reset,
    regfile_writeback_if.slave  wb,
    input  logic                rf_hold,
    output logic [ADDR_W-1:0]   RD,
    output logic [DATA_W-1:0]   WriteData,
    output logic                RegWrite,
    input  logic [ADDR_W-1:0]   RS,
    input  logic [ADDR_W-1:0]   RT,
    input  logic [DATA_W-1:0]   ReadRS,
    input  logic [DATA_W-1:0]   ReadRT,
    output logic [DATA_W-1:0]   FwdRS,
    output logic [DATA_W-1:0]   FwdRT,
    output logic [CNT_W-1:0]    pending
);

    import cpu_pkg::*;

    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] ent_rd   [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic              has_entry;
    logic              drain;
    logic              accept;

    wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .Clock       (Clock),
        .Reset       (Reset),
        .push_i      (accept),
        .push_rd_i   (wb.wb_rd),
        .push_data_i (wb.wb_data),
        .pop_i       (drain),
        .count_o     (count),
        .ent_rd_o    (ent_rd),
        .ent_data_o  (ent_data),
        .ent_valid_o (ent_valid)
    );

    // Drain/accept control; a draining full buffer can still take a push.
    always_comb begin
        has_entry   = (count != '0);
        drain       = has_entry && !rf_hold;
        wb.wb_ready = (count < CNT_W'(DEPTH)) || drain;
        accept      = wb.wb_valid && wb.wb_ready;
        RegWrite    = drain;
        RD          = has_entry ? ent_rd[0]   : '0;
        WriteData   = has_entry ? ent_data[0] : '0;
        pending     = count;
    end

    // Newest-first forwarding: scan oldest to newest so later matches win.
    always_comb begin
        FwdRS = ReadRS;
        FwdRT = ReadRT;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (ent_valid[k] && (ent_rd[k] == RS)) begin
                FwdRS = ent_data[k];
            end
            if (ent_valid[k] && (ent_rd[k] == RT)) begin
                FwdRT = ent_data[k];
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model and a model register file.
module tb_regfile_writeback;

    import cpu_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic              rf_hold = 1'b0;
    logic [ADDR_W-1:0] RD;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;
    logic [ADDR_W-1:0] RS = '0;
    logic [ADDR_W-1:0] RT = '0;
    logic [DATA_W-1:0] ReadRS;
    logic [DATA_W-1:0] ReadRT;
    logic [DATA_W-1:0] FwdRS;
    logic [DATA_W-1:0] FwdRT;
    logic [1:0]        pending;

    regfile_writeback_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wbif ();

    regfile_writeback #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .wb        (wbif.slave),
        .rf_hold   (rf_hold),
        .RD        (RD),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .RS        (RS),
        .RT        (RT),
        .ReadRS    (ReadRS),
        .ReadRT    (ReadRT),
        .FwdRS     (FwdRS),
        .FwdRT     (FwdRT),
        .pending   (pending)
    );

    always #5 Clock = ~Clock;

    // Register file driven by the DUT write port.
    logic [DATA_W-1:0] rf  [NUM_REGS] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    // Reference register file driven by the model.
    logic [DATA_W-1:0] mrf [NUM_REGS] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};

    always @(posedge Clock) begin
        if (RegWrite) rf[RD] <= WriteData;
    end
    assign ReadRS = rf[RS];
    assign ReadRT = rf[RT];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of pending writes, oldest first.
    wb_entry_t         mq[$];
    bit                m_acc = 1'b0;
    bit                m_drn;
    bit                m_rdy;
    wb_entry_t         m_e;

    function automatic logic [DATA_W-1:0] fwd_model(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] r;
        r = mrf[a];
        foreach (mq[i]) if (mq[i].rd == a) r = mq[i].data;
        return r;
    endfunction

    always @(posedge Reset) mq.delete();

    // Compare every cycle, then advance the model to the next edge.
    always @(negedge Clock) begin
        if (Reset) mq.delete();
        m_drn = (mq.size() != 0) && !rf_hold;
        m_rdy = (mq.size() < DEPTH) || m_drn;
        chk("wb_ready",  {31'd0, wbif.wb_ready}, {31'd0, m_rdy});
        chk("RegWrite",  {31'd0, RegWrite},      {31'd0, m_drn});
        chk("pending",   {30'd0, pending},       mq.size());
        chk("RD",        {30'd0, RD},            (mq.size() != 0) ? {30'd0, mq[0].rd} : 32'd0);
        chk("WriteData", {16'd0, WriteData},     (mq.size() != 0) ? {16'd0, mq[0].data} : 32'd0);
        chk("FwdRS",     {16'd0, FwdRS},         {16'd0, fwd_model(RS)});
        chk("FwdRT",     {16'd0, FwdRT},         {16'd0, fwd_model(RT)});
        m_acc = 1'b0;
        if (!Reset) begin
            if (m_drn) begin
                m_e = mq.pop_front();
                mrf[m_e.rd] = m_e.data;
            end
            if (wbif.wb_valid && m_rdy) begin
                mq.push_back(wb_entry_t'{rd: wbif.wb_rd, data: wbif.wb_data});
                m_acc = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic req(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        wbif.wb_valid = 1'b1;
        wbif.wb_rd    = r;
        wbif.wb_data  = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wbif.wb_valid = 1'b0;
        wbif.wb_rd    = '0;
        wbif.wb_data  = '0;
        #3;
        chk("rst_pending",  {30'd0, pending},       32'd0);
        chk("rst_RegWrite", {31'd0, RegWrite},      32'd0);
        chk("rst_RD",       {30'd0, RD},            32'd0);
        chk("rst_WD",       {16'd0, WriteData},     32'd0);
        chk("rst_ready",    {31'd0, wbif.wb_ready}, 32'd1);
        chk("rst_FwdRS",    {16'd0, FwdRS},         32'hA000);
        step();
        Reset = 1'b0;
        step();

        // Single request.
        req(1, 5); RS = 1;
        #2;
        chk("t1_ready",    {31'd0, wbif.wb_ready}, 32'd1);
        chk("t1_nofwd",    {16'd0, FwdRS},         32'hA001);
        step(); wbif.wb_valid = 1'b0;
        #2;
        chk("t1_RegWrite", {31'd0, RegWrite},  32'd1);
        chk("t1_RD",       {30'd0, RD},        32'd1);
        chk("t1_WD",       {16'd0, WriteData}, 32'd5);
        chk("t1_FwdRS",    {16'd0, FwdRS},     32'd5);
        chk("t1_rawold",   {16'd0, ReadRS},    32'hA001);
        step();
        #2;
        chk("t1_raw",      {16'd0, ReadRS},    32'd5);
        chk("t1_idle",     {31'd0, RegWrite},  32'd0);

        // Back-to-back requests.
        step(); req(1, 5);
        #2; chk("t2_ready0", {31'd0, wbif.wb_ready}, 32'd1);
        step(); req(2, 7);
        #2;
        chk("t2_ready1", {31'd0, wbif.wb_ready}, 32'd1);
        chk("t2_c1_RD",  {30'd0, RD},        32'd1);
        chk("t2_c1_WD",  {16'd0, WriteData}, 32'd5);
        step(); wbif.wb_valid = 1'b0;
        #2;
        chk("t2_c2_WE",  {31'd0, RegWrite},  32'd1);
        chk("t2_c2_RD",  {30'd0, RD},        32'd2);
        chk("t2_c2_WD",  {16'd0, WriteData}, 32'd7);
        step(); RS = 1; RT = 2;
        #2;
        chk("t2_rawRS",  {16'd0, ReadRS}, 32'd5);
        chk("t2_rawRT",  {16'd0, ReadRT}, 32'd7);

        // Hold with three requests to the same register.
        step(); rf_hold = 1'b1; req(3, 9); RS = 3;
        #2; chk("t3_p0", {30'd0, pending}, 32'd0);
        step(); req(3, 10);
        #2;
        chk("t3_p1",    {30'd0, pending}, 32'd1);
        chk("t3_fwd9",  {16'd0, FwdRS},   32'd9);
        step(); req(3, 11);
        #2;
        chk("t3_p2",    {30'd0, pending},       32'd2);
        chk("t3_full",  {31'd0, wbif.wb_ready}, 32'd0);
        chk("t3_fwd10", {16'd0, FwdRS},         32'd10);
        step();
        #2; chk("t3_still_full", {31'd0, wbif.wb_ready}, 32'd0);
        step(); rf_hold = 1'b0;
        #2;
        chk("t3_rel_ready", {31'd0, wbif.wb_ready}, 32'd1);
        chk("t3_rel_WD9",   {16'd0, WriteData},     32'd9);
        step(); wbif.wb_valid = 1'b0;
        #2;
        chk("t3_fullpush_p", {30'd0, pending},   32'd2);
        chk("t3_WD10",       {16'd0, WriteData}, 32'd10);
        chk("t3_fwd11",      {16'd0, FwdRS},     32'd11);
        step();
        #2;
        chk("t3_WD11",  {16'd0, WriteData}, 32'd11);
        step();
        #2;
        chk("t3_empty", {30'd0, pending}, 32'd0);
        chk("t3_raw11", {16'd0, ReadRS},  32'd11);

        // Asynchronous reset with two entries pending.
        step(); rf_hold = 1'b1; req(2, 16'h1234);
        step(); req(1, 16'h4321);
        step(); wbif.wb_valid = 1'b0;
        #2; chk("t5_p2", {30'd0, pending}, 32'd2);
        step(); rf_hold = 1'b0;
        #1; chk("t5_pre_WE", {31'd0, RegWrite}, 32'd1);
        Reset = 1'b1;
        #1;
        chk("t5_WE",    {31'd0, RegWrite},      32'd0);
        chk("t5_p",     {30'd0, pending},       32'd0);
        chk("t5_ready", {31'd0, wbif.wb_ready}, 32'd1);
        Reset = 1'b0;
        step(); RS = 2; RT = 1;
        step();
        #2;
        chk("t5_rf2", {16'd0, ReadRS}, 32'd7);
        chk("t5_rf1", {16'd0, ReadRT}, 32'd5);

        // Same destination twice.
        step(); rf_hold = 1'b1; RT = 0; req(0, 1);
        step(); req(0, 2);
        step(); wbif.wb_valid = 1'b0;
        #2;
        chk("t6_fwd2", {16'd0, FwdRT},  32'd2);
        chk("t6_raw0", {16'd0, ReadRT}, 32'hA000);
        step(); rf_hold = 1'b0;
        step();
        step();
        #2;
        chk("t6_raw2", {16'd0, ReadRT}, 32'd2);

        // Randomized traffic; a refused request is held stable.
        for (int c = 0; c < 3000; c++) begin
            step();
            if (!(wbif.wb_valid && !m_acc)) begin
                wbif.wb_valid = ($urandom_range(0, 99) < 60);
                wbif.wb_rd    = ADDR_W'($urandom);
                wbif.wb_data  = DATA_W'($urandom);
            end
            rf_hold = ($urandom_range(0, 99) < 35);
            RS      = ADDR_W'($urandom);
            RT      = ADDR_W'($urandom);
        end
        step();
        wbif.wb_valid = 1'b0;
        rf_hold       = 1'b0;
        step();
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side companion of `registerFile`: buffers register writeback requests from the execute/memory stages and drives the register file's single write port (`RD`, `WriteData`, `RegWrite`) at one write per cycle. It also forwards pending, not-yet-committed write data onto the two read paths, so readers of `RS`/`RT` see the newest value. It sits between the pipeline's writeback stage and `registerFile`, and owns all writes into it.

## Interface
Parameters:
- `DEPTH`, 2: pending-write buffer entries; power of two, ≥2.
- `ADDR_W`, 2: register address width (4 registers).
- `DATA_W`, 16: register data width.

Ports:
- `Clock`  in  1: single clock; all state updates on rising edge.
- `Reset`  in  1: asynchronous, active-high; clears all state immediately.
- `wb_valid`  in  1: writeback request present.
- `wb_rd`  in  ADDR_W: destination register.
- `wb_data`  in  DATA_W: value to write.
- `wb_ready`  out  1: request accepted this cycle when `wb_valid && wb_ready`.
- `rf_hold`  in  1: suppress draining this cycle (debug/stall).
- `RD`  out  ADDR_W: to `registerFile` write address.
- `WriteData`  out  DATA_W: to `registerFile` write data.
- `RegWrite`  out  1: to `registerFile` write enable.
- `RS`, `RT`  in  ADDR_W: read addresses, also wired to `registerFile`.
- `ReadRS`, `ReadRT`  in  DATA_W: raw `registerFile` read data.
- `FwdRS`, `FwdRT`  out  DATA_W: forwarded read data.
- `pending`  out  $clog2(DEPTH)+1: current entry count.

## Operation
- FIFO of {rd, data} entries, oldest first; `pending` = entry count.
- `wb_ready = (pending < DEPTH) || drain`, where `drain = (pending != 0) && !rf_hold`. Push and drain in the same cycle is allowed even when full; the count is unchanged.
- Write port: `RegWrite = drain`. `RD`/`WriteData` equal the head entry when `pending != 0`, else 0. The register file commits the head at the end of that cycle, and the entry is popped at the same edge.
- Forwarding is combinational: `FwdRS` = data of the newest FIFO entry whose rd equals `RS`; if none matches, `ReadRS`. `FwdRT` is resolved identically and independently. The incoming `wb_*` request is not forwarded in its accept cycle.
- Two entries with the same rd are both written in order; the last one wins in the register file, and the newest wins for forwarding.
- All four registers are writable; there is no hardwired zero register.
- `wb_valid` while `!wb_ready`: the request is ignored. The sender must hold `wb_rd` and `wb_data` stable until it is accepted.

## Timing
- Reset (async assert): `pending=0`, pointers 0, `RegWrite=0`, `RD=0`, `WriteData=0`, `wb_ready=1`. The forward outputs then equal the raw read data.
- Reset mid-operation discards all un-drained entries; nothing is written to the register file after `Reset` asserts.
- Latency: a request accepted at edge N is the head in cycle N+1 (if the FIFO was empty) and is committed to the register file at edge N+1. A raw read of that register reflects it from cycle N+2.
- Forwarding covers cycle N+1, so `FwdRS`/`FwdRT` show the new value from cycle N+1 onward.
- Back-to-back requests are accepted with no bubble: one commit per cycle.
- With `rf_hold=1`, entries accumulate. `wb_ready` drops in the cycle `pending == DEPTH`. When `rf_hold` clears, draining resumes the next cycle at one entry per cycle.
- Pointer wrap: modulo DEPTH with no gap. Full and empty are distinguished by `pending`, not by the pointers.

## Structure
- Shared package `cpu_pkg` holds:
  - constants `ADDR_W=2`, `DATA_W=16`, `NUM_REGS=4`
  - typedef `wb_entry_t` = {rd, data}
- Sub-module `wb_fifo`: storage, pointers, count, push/pop, and exposure of all entries plus valid bits for the forwarding compare.
- Top level contains the drain control and the newest-first forward priority muxes.

## Test plan
- Reset, then a single request (rd=1, data=5) -> `RegWrite=1`, `RD=1`, `WriteData=5` next cycle. `FwdRS=5` with `RS=1` in the same cycle. Raw `ReadRS=5` the following cycle.
- Back-to-back requests (rd=1, data=5) then (rd=2, data=7) -> two consecutive commits, `wb_ready` held at 1 throughout. Afterwards, `RS=1`/`RT=2` read 5/7.
- `rf_hold=1` with three requests (rd=3: 9, 10, 11) -> the first two are accepted and `wb_ready=0` at `pending=2`. `FwdRS` with `RS=3` equals 10. After release, commits are 9 then 10, the third request is accepted, and the final value is 11.
- Full FIFO with `rf_hold=0` and a simultaneous push -> accepted, `pending` stays 2, no loss or duplication.
- `Reset` pulse asserted between clock edges while `pending=2` -> `RegWrite` drops immediately, `pending=0`, and the register file is unchanged afterwards.
- Same rd in both entries (rd=0: 1 then 2) with `RT=0` -> `FwdRT=2` while both are pending. After both commits, raw `ReadRT=2`.
